// File: rtl/pwm_pkg.sv
// Shared types for the center-aligned PWM stage: one-hot dead-time FSM states
// and the state the FSM wakes up in after reset.
package pwm_pkg;

    typedef enum logic [3:0] {
        LO_ON    = 4'b0001,
        DT_TO_HI = 4'b0010,
        HI_ON    = 4'b0100,
        DT_TO_LO = 4'b1000
    } pwm_state_t;

    // Waking in a dead-time window guarantees both gates start released.
    localparam pwm_state_t PWM_RESET_STATE = DT_TO_LO;

endpackage

// File: rtl/deadtime_inserter.sv
// Converts a registered demand level into a complementary gate pair with a
// programmable break-before-make gap of dead_time+1 cycles.
module deadtime_inserter
    import pwm_pkg::*;
#(
    parameter int DT_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            demand,
    input  logic [DT_W-1:0] dead_time,
    output logic            pwm_hi,
    output logic            pwm_lo
);

    pwm_state_t      state, state_nxt;
    logic [DT_W-1:0] cnt, cnt_nxt;
    logic [DT_W-1:0] dt_lat, dt_lat_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= PWM_RESET_STATE;
            cnt    <= '0;
            dt_lat <= dead_time;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            dt_lat <= dt_lat_nxt;
        end
    end

    // dead_time is latched only when a window opens; cnt stops at dt_lat.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        dt_lat_nxt = dt_lat;
        case (state)
            LO_ON: begin
                if (demand) begin
                    state_nxt  = DT_TO_HI;
                    cnt_nxt    = '0;
                    dt_lat_nxt = dead_time;
                end
            end
            DT_TO_HI: begin
                if (!demand) begin
                    state_nxt = LO_ON;
                end else if (cnt == dt_lat) begin
                    state_nxt = HI_ON;
                end else begin
                    cnt_nxt = cnt + DT_W'(1);
                end
            end
            HI_ON: begin
                if (!demand) begin
                    state_nxt  = DT_TO_LO;
                    cnt_nxt    = '0;
                    dt_lat_nxt = dead_time;
                end
            end
            DT_TO_LO: begin
                if (demand) begin
                    state_nxt = HI_ON;
                end else if (cnt == dt_lat) begin
                    state_nxt = LO_ON;
                end else begin
                    cnt_nxt = cnt + DT_W'(1);
                end
            end
            default: begin
                state_nxt  = PWM_RESET_STATE;
                cnt_nxt    = '0;
                dt_lat_nxt = dead_time;
            end
        endcase
    end

    assign pwm_hi = (state == HI_ON);
    assign pwm_lo = (state == LO_ON);

endmodule

// File: rtl/center_pwm.sv
// Center-aligned PWM: double-buffered duty committed at the carrier valley,
// registered compare against the triangle, then dead-time insertion.
module center_pwm
    import pwm_pkg::*;
#(
    parameter int N    = 8,
    parameter int DT_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ena,
    input  logic [N-1:0]    carrier,
    input  logic [N-1:0]    duty_in,
    input  logic            duty_wr,
    input  logic [DT_W-1:0] dead_time,
    output logic            pwm_hi,
    output logic            pwm_lo,
    output logic [N-1:0]    duty_active,
    output logic            sync
);

    logic [N-1:0] shadow;
    logic         demand;
    logic         valley;

    assign valley = ena && (carrier == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
        end else if (duty_wr) begin
            shadow <= duty_in;
        end
    end

    // Commit sees the pre-edge shadow, so a same-cycle write waits a period.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_active <= '0;
            sync        <= 1'b0;
        end else begin
            sync <= valley;
            if (valley) begin
                duty_active <= shadow;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            demand <= 1'b0;
        end else begin
            demand <= (carrier < duty_active);
        end
    end

    deadtime_inserter #(
        .DT_W(DT_W)
    ) u_dt (
        .clk      (clk),
        .rst      (rst),
        .demand   (demand),
        .dead_time(dead_time),
        .pwm_hi   (pwm_hi),
        .pwm_lo   (pwm_lo)
    );

endmodule

// File: tb/tb_center_pwm.sv
// Directed bench for center_pwm: reset/idle, nominal triangle, commit
// atomicity, aborted dead time, dead-time latching, extremes and hold.
module tb_center_pwm;
    import pwm_pkg::*;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] carrier;
    logic [7:0] duty_in;
    logic       duty_wr;
    logic [3:0] dead_time;
    logic       pwm_hi;
    logic       pwm_lo;
    logic [7:0] duty_active;
    logic       sync;

    int n_cmp;
    int n_bad;
    logic       run_chk;
    logic       dir_up;
    logic [7:0] c_last;
    logic [7:0] c_prev2;
    logic       valley_last;

    center_pwm #(.N(8), .DT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .carrier    (carrier),
        .duty_in    (duty_in),
        .duty_wr    (duty_wr),
        .dead_time  (dead_time),
        .pwm_hi     (pwm_hi),
        .pwm_lo     (pwm_lo),
        .duty_active(duty_active),
        .sync       (sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gates must never overlap, checked every cycle once reset has run.
    always @(negedge clk) begin
        if (run_chk && !rst) begin
            n_cmp++;
            if (pwm_hi === 1'b1 && pwm_lo === 1'b1) begin
                n_bad++;
                $display("FAIL overlap: pwm_hi=%b pwm_lo=%b required not both 1", pwm_hi, pwm_lo);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Up/down triangle generator model: 0..255..0, period 510 when ena is 1.
    task automatic tri_tick();
        @(posedge clk);
        #1;
        c_prev2     = c_last;
        c_last      = carrier;
        valley_last = ena && (carrier == 8'd0);
        if (ena) begin
            if (dir_up) begin
                if (carrier == 8'd255) begin
                    dir_up  = 1'b0;
                    carrier = 8'd254;
                end else begin
                    carrier = carrier + 8'd1;
                end
            end else begin
                if (carrier == 8'd0) begin
                    dir_up  = 1'b1;
                    carrier = 8'd1;
                end else begin
                    carrier = carrier - 8'd1;
                end
            end
        end
    endtask

    task automatic do_reset(input logic [3:0] dt);
        rst       = 1'b1;
        dead_time = dt;
        duty_wr   = 1'b0;
        tick();
        tick();
        rst     = 1'b0;
        run_chk = 1'b1;
        dir_up  = 1'b1;
        c_last  = carrier;
        c_prev2 = carrier;
    endtask

    task automatic test_reset();
        ena = 1'b0; carrier = 8'd0; duty_in = 8'd0;
        do_reset(4'd3);
        n_cmp++;
        if (pwm_hi !== 1'b0 || pwm_lo !== 1'b0 || sync !== 1'b0 || duty_active !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_values: hi=%b lo=%b sync=%b duty=%0d required 0 0 0 0",
                     pwm_hi, pwm_lo, sync, duty_active);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (pwm_hi !== 1'b0 || pwm_lo !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_dt_window[%0d]: hi=%b lo=%b required 0 0", i, pwm_hi, pwm_lo);
            end
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (pwm_lo !== 1'b1 || pwm_hi !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_idle_lo[%0d]: hi=%b lo=%b required 0 1", i, pwm_hi, pwm_lo);
            end
        end
    endtask

    task automatic test_nominal();
        int   hi_cnt;
        int   sync_cnt;
        int   run_len;
        int   n_runs;
        logic found;
        ena = 1'b1; carrier = 8'd0; duty_in = 8'd0;
        do_reset(4'd2);
        for (int i = 0; i < 40; i++) tri_tick();
        duty_in = 8'd64; duty_wr = 1'b1;
        tri_tick();
        duty_wr = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            tri_tick();
            if (sync === 1'b1) found = 1'b1;
        end
        n_cmp++;
        if (!found || duty_active !== 8'd64) begin
            n_bad++;
            $display("FAIL nominal_commit: sync_seen=%b duty=%0d required 1 64", found, duty_active);
        end
        for (int i = 0; i < 300; i++) tri_tick();
        hi_cnt = 0; sync_cnt = 0; run_len = 0; n_runs = 0;
        for (int i = 0; i < 1020; i++) begin
            tri_tick();
            n_cmp++;
            if (sync !== valley_last) begin
                n_bad++;
                $display("FAIL nominal_sync: sync=%b required %b", sync, valley_last);
            end
            n_cmp++;
            if ((pwm_hi === 1'b1 && c_prev2 >= 8'd64) || (pwm_lo === 1'b1 && c_prev2 < 8'd64)) begin
                n_bad++;
                $display("FAIL nominal_gate_vs_carrier: hi=%b lo=%b carrier=%0d required hi iff <64",
                         pwm_hi, pwm_lo, c_prev2);
            end
            if (pwm_hi === 1'b1) hi_cnt++;
            if (sync === 1'b1) sync_cnt++;
            if (pwm_hi === 1'b0 && pwm_lo === 1'b0) begin
                run_len++;
            end else if (run_len > 0) begin
                n_cmp++;
                if (run_len != 3) begin
                    n_bad++;
                    $display("FAIL nominal_dead_time: gap=%0d required 3", run_len);
                end
                n_runs++;
                run_len = 0;
            end
        end
        n_cmp++;
        if (hi_cnt != 248 || sync_cnt != 2 || n_runs != 4) begin
            n_bad++;
            $display("FAIL nominal_counts: hi=%0d sync=%0d gaps=%0d required 248 2 4",
                     hi_cnt, sync_cnt, n_runs);
        end
    endtask

    task automatic test_commit();
        ena = 1'b1; carrier = 8'd0; duty_in = 8'd0;
        do_reset(4'd1);
        for (int i = 0; i < 600 && carrier != 8'd50; i++) tri_tick();
        duty_in = 8'd100; duty_wr = 1'b1;
        tri_tick();
        duty_wr = 1'b0;
        for (int i = 0; i < 600 && carrier != 8'd150; i++) tri_tick();
        duty_in = 8'd200; duty_wr = 1'b1;
        tri_tick();
        duty_wr = 1'b0;
        n_cmp++;
        if (duty_active !== 8'd0) begin
            n_bad++;
            $display("FAIL commit_midperiod: duty=%0d required 0", duty_active);
        end
        for (int i = 0; i < 600 && carrier != 8'd0; i++) tri_tick();
        n_cmp++;
        if (carrier !== 8'd0) begin
            n_bad++;
            $display("FAIL commit_find_valley: carrier=%0d required 0", carrier);
        end
        duty_in = 8'd50; duty_wr = 1'b1;
        tri_tick();
        duty_wr = 1'b0;
        n_cmp++;
        if (duty_active !== 8'd200 || sync !== 1'b1) begin
            n_bad++;
            $display("FAIL commit_last_wins: duty=%0d sync=%b required 200 1", duty_active, sync);
        end
        for (int i = 0; i < 600 && carrier != 8'd0; i++) begin
            tri_tick();
            n_cmp++;
            if (duty_active !== 8'd200) begin
                n_bad++;
                $display("FAIL commit_hold: duty=%0d required 200", duty_active);
            end
        end
        tri_tick();
        n_cmp++;
        if (duty_active !== 8'd50 || sync !== 1'b1) begin
            n_bad++;
            $display("FAIL commit_same_cycle_write: duty=%0d sync=%b required 50 1", duty_active, sync);
        end
    endtask

    task automatic test_abort();
        ena = 1'b0; carrier = 8'd200; duty_in = 8'd0;
        do_reset(4'd7);
        for (int i = 0; i < 10; i++) tick();
        duty_in = 8'd10; duty_wr = 1'b1;
        tick();
        duty_wr = 1'b0;
        carrier = 8'd0; ena = 1'b1;
        tick();
        carrier = 8'd5; ena = 1'b0;
        n_cmp++;
        if (duty_active !== 8'd10 || sync !== 1'b1 || pwm_lo !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_setup: duty=%0d sync=%b lo=%b required 10 1 1", duty_active, sync, pwm_lo);
        end
        tick();
        tick();
        carrier = 8'd200;
        n_cmp++;
        if (dut.u_dt.state !== DT_TO_HI || pwm_lo !== 1'b0 || pwm_hi !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_enter: state=%b hi=%b lo=%b required 0010 0 0",
                     dut.u_dt.state, pwm_hi, pwm_lo);
        end
        tick();
        n_cmp++;
        if (pwm_lo !== 1'b0 || pwm_hi !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_window: hi=%b lo=%b required 0 0", pwm_hi, pwm_lo);
        end
        tick();
        n_cmp++;
        if (dut.u_dt.state !== LO_ON || pwm_lo !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_return: state=%b lo=%b required 0001 1", dut.u_dt.state, pwm_lo);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (pwm_hi !== 1'b0) begin
                n_bad++;
                $display("FAIL abort_hi_quiet: hi=%b required 0", pwm_hi);
            end
        end
    endtask

    task automatic test_dt_latch();
        ena = 1'b0; carrier = 8'd200; duty_in = 8'd0;
        do_reset(4'd1);
        for (int i = 0; i < 5; i++) tick();
        duty_in = 8'd100; duty_wr = 1'b1;
        tick();
        duty_wr = 1'b0;
        carrier = 8'd0; ena = 1'b1;
        tick();
        carrier = 8'd5; ena = 1'b0;
        tick();
        tick();
        dead_time = 4'd7;
        tick();
        n_cmp++;
        if (pwm_hi !== 1'b0 || pwm_lo !== 1'b0) begin
            n_bad++;
            $display("FAIL dt_latch_window: hi=%b lo=%b required 0 0", pwm_hi, pwm_lo);
        end
        tick();
        n_cmp++;
        if (pwm_hi !== 1'b1) begin
            n_bad++;
            $display("FAIL dt_latch_hi: hi=%b required 1", pwm_hi);
        end
    endtask

    task automatic test_extremes();
        int   nohi_cnt;
        logic found;
        ena = 1'b1; carrier = 8'd0; duty_in = 8'd0;
        do_reset(4'd0);
        for (int i = 0; i < 1100; i++) begin
            tri_tick();
            n_cmp++;
            if (pwm_hi !== 1'b0) begin
                n_bad++;
                $display("FAIL duty0_hi: hi=%b required 0", pwm_hi);
            end
        end

        carrier = 8'd0; duty_in = 8'd255;
        do_reset(4'd0);
        duty_wr = 1'b1;
        tri_tick();
        duty_wr = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            tri_tick();
            if (sync === 1'b1) found = 1'b1;
        end
        for (int i = 0; i < 10; i++) tri_tick();
        n_cmp++;
        if (!found || duty_active !== 8'd255) begin
            n_bad++;
            $display("FAIL duty255_commit: sync_seen=%b duty=%0d required 1 255", found, duty_active);
        end
        nohi_cnt = 0;
        for (int i = 0; i < 510; i++) begin
            tri_tick();
            if (pwm_hi !== 1'b1) nohi_cnt++;
            n_cmp++;
            if (pwm_lo === 1'b1 && c_prev2 != 8'd255) begin
                n_bad++;
                $display("FAIL duty255_lo: lo=%b carrier=%0d required lo only at 255", pwm_lo, c_prev2);
            end
        end
        n_cmp++;
        if (nohi_cnt != 1) begin
            n_bad++;
            $display("FAIL duty255_gap: hi_low_cycles=%0d required 1", nohi_cnt);
        end

        ena = 1'b0; carrier = 8'd0; duty_in = 8'd30;
        do_reset(4'd0);
        duty_wr = 1'b1;
        tick();
        duty_wr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (sync !== 1'b0 || duty_active !== 8'd0) begin
                n_bad++;
                $display("FAIL hold_no_commit: sync=%b duty=%0d required 0 0", sync, duty_active);
            end
        end
        ena = 1'b1;
        tick();
        ena = 1'b0;
        duty_in = 8'd40; duty_wr = 1'b1;
        n_cmp++;
        if (sync !== 1'b1 || duty_active !== 8'd30) begin
            n_bad++;
            $display("FAIL hold_commit: sync=%b duty=%0d required 1 30", sync, duty_active);
        end
        tick();
        duty_wr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (sync !== 1'b0 || duty_active !== 8'd30) begin
                n_bad++;
                $display("FAIL hold_no_repeat: sync=%b duty=%0d required 0 30", sync, duty_active);
            end
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; run_chk = 1'b0;
        rst = 1'b1; ena = 1'b0; carrier = 8'd0; duty_in = 8'd0; duty_wr = 1'b0;
        dead_time = 4'd0; dir_up = 1'b1;
        c_last = 8'd0; c_prev2 = 8'd0; valley_last = 1'b0;
        test_reset();
        test_nominal();
        test_commit();
        test_abort();
        test_dt_latch();
        test_extremes();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
